// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } sched_state_t;

  // Fill value for the unused upper bits of the source-ID header beat.
  localparam logic HDR_PAD = 1'b0;

  // Width of a grant index; a single source still gets a 1-bit index.
  function automatic int grant_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_picker.sv
// Round-robin picker: first set request at or above i_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; pure function of i_req and i_ptr.
// Ports: i_req  request vector (N bits)
//        i_ptr  search start index, must be < N
//        o_found any request set; o_idx winning index
module rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  // One extra bit so ptr + offset can exceed N before the wrap subtraction.
  logic [W:0] w_j;

  assign o_found = |i_req;

  always_comb begin
    w_j   = '0;
    o_idx = '0;
    // Walk offsets downward so the smallest offset from the pointer wins.
    for (int k = N - 1; k >= 0; k--) begin
      w_j = {1'b0, i_ptr} + (W + 1)'(k);
      if (w_j >= (W + 1)'(N)) w_j = w_j - (W + 1)'(N);
      if ((i_req & (N'(1) << w_j)) != '0) o_idx = w_j[W-1:0];
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Packet-level round-robin mux of N AXI-stream sources onto one UART tx stream.
// Latency: grant 1 cycle after request, header beat at 2, first data at 3.
// Backpressure: registered output; sources see ready only when the slot frees.
// Ports: clk/reset (async active-low); s_t* per-source streams (slice i = source i);
//        m_t* registered output stream; grant_id current/last grant; busy in
//        HEADER/DATA; burst_truncated one-cycle pulse on a forced release.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int N_SOURCES  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_HEADER  = 1,
  parameter int MAX_BURST  = 64,
  localparam int GW        = grant_width(N_SOURCES)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_SOURCES*DATA_WIDTH-1:0] s_tdata,
  input  logic [N_SOURCES-1:0]            s_tvalid,
  input  logic [N_SOURCES-1:0]            s_tlast,
  output logic [N_SOURCES-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  input  logic                            m_tready,
  output logic [GW-1:0]                   grant_id,
  output logic                            busy,
  output logic                            burst_truncated
);

  // Beat counter only needs to reach MAX_BURST; unlimited mode lets it wrap.
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  sched_state_t          r_state, w_state_nxt;
  logic [GW-1:0]         r_grant, r_rr, w_rr_nxt, w_pick_idx;
  logic [CW-1:0]         r_cnt, w_cnt_inc;
  logic [DATA_WIDTH-1:0] r_m_tdata, w_src_data, w_hdr;
  logic                  r_m_tvalid, r_m_tlast, r_trunc;
  logic                  w_pick_found, w_slot_free, w_src_vld, w_src_last;
  logic                  w_acc, w_limit, w_pkt_end, w_hdr_load;

  rr_picker #(.N(N_SOURCES), .W(GW)) u_pick (
    .i_req   (s_tvalid),
    .i_ptr   (r_rr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  assign w_slot_free = !r_m_tvalid || m_tready;
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_limit     = (MAX_BURST != 0) && (w_cnt_inc == CW'(MAX_BURST));
  assign w_acc       = (r_state == ST_DATA) && w_slot_free && w_src_vld;
  assign w_pkt_end   = w_acc && (w_src_last || w_limit);
  assign w_hdr_load  = (r_state == ST_HEADER) && w_slot_free;
  assign w_rr_nxt    = (r_grant == GW'(N_SOURCES - 1)) ? '0 : r_grant + GW'(1);

  // Granted-source select and ready fan-out.
  always_comb begin
    w_src_vld  = 1'b0;
    w_src_last = 1'b0;
    w_src_data = '0;
    s_tready   = '0;
    for (int i = 0; i < N_SOURCES; i++) begin
      if (r_grant == GW'(i)) begin
        w_src_vld   = s_tvalid[i];
        w_src_last  = s_tlast[i];
        w_src_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        s_tready[i] = (r_state == ST_DATA) && w_slot_free;
      end
    end
  end

  always_comb begin
    w_hdr         = {DATA_WIDTH{HDR_PAD}};
    w_hdr[GW-1:0] = r_grant;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_pick_found) w_state_nxt = (ID_HEADER != 0) ? ST_HEADER : ST_DATA;
      ST_HEADER: if (w_slot_free) w_state_nxt = ST_DATA;
      ST_DATA:   if (w_pkt_end) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant    <= '0;
      r_rr       <= '0;
      r_cnt      <= '0;
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_trunc    <= 1'b0;
    end else begin
      // Pulse the cycle after a limit-forced end that the source did not mark.
      r_trunc <= w_acc && w_limit && !w_src_last;
      if ((r_state == ST_IDLE) && w_pick_found) begin
        r_grant <= w_pick_idx;
        r_cnt   <= '0;
      end
      if (w_acc)     r_cnt <= w_cnt_inc;
      if (w_pkt_end) r_rr  <= w_rr_nxt;
      if (w_hdr_load) begin
        r_m_tdata  <= w_hdr;
        r_m_tlast  <= 1'b0;
        r_m_tvalid <= 1'b1;
      end else if (w_acc) begin
        r_m_tdata  <= w_src_data;
        r_m_tlast  <= w_src_last || w_limit;
        r_m_tvalid <= 1'b1;
      end else if (m_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign m_tdata         = r_m_tdata;
  assign m_tvalid        = r_m_tvalid;
  assign m_tlast         = r_m_tlast;
  assign grant_id        = r_grant;
  assign busy            = (r_state != ST_IDLE);
  assign burst_truncated = r_trunc;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single UART transmit stream between N_SOURCES AXI-stream requesters, one packet at a time, with round-robin fairness.
- Grant is held from the first beat until tlast, or until a forced release at MAX_BURST beats.
- Each packet is optionally prefixed with a source-ID byte so the host can demultiplex.
- The output drives the UART tx sink stream (DATA_WIDTH = 8); the output beat is registered.

Parameters:
N_SOURCES, 4, number of requesting streams (1..16).
DATA_WIDTH, 8, beat width; must satisfy clog2(N_SOURCES) <= DATA_WIDTH.
ID_HEADER, 1, 1 = emit a header beat carrying the zero-extended grant index before each packet; 0 = no header.
MAX_BURST, 64, maximum data beats per grant; 0 = unlimited.

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  asynchronous, active-low reset.
s_tdata  input  N_SOURCES*DATA_WIDTH  source payloads; source i occupies slice i.
s_tvalid  input  N_SOURCES  per-source valid.
s_tlast  input  N_SOURCES  per-source end of packet.
s_tready  output  N_SOURCES  per-source ready; only the granted bit can be 1.
m_tdata  output  DATA_WIDTH  beat to the UART tx stream.
m_tvalid  output  1  output valid.
m_tlast  output  1  output end of packet.
m_tready  input  1  UART ready.
grant_id  output  clog2(max(N_SOURCES,2))  current or last granted source.
busy  output  1  high in HEADER or DATA.
burst_truncated  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (reset low, asynchronous assert, synchronous release):
  - state = IDLE, rr pointer = 0, grant_id = 0, beat count = 0.
  - m_tvalid, m_tlast, m_tdata, s_tready, busy and burst_truncated all = 0.
  - Asserting reset mid-packet drops the in-flight beat. There is no recovery of the partial packet.
- Output register:
  - A new beat loads when slot_free = !m_tvalid || m_tready. Otherwise m_* hold stable.
  - m_tvalid clears on a handshake when no new beat is loaded.
- IDLE:
  - busy = 0; all s_tready = 0.
  - If any s_tvalid is set, the winner is the first set bit searching upward from the rr pointer, with wrap.
  - On a win: register grant_id and clear the beat count. Go to HEADER if ID_HEADER, else DATA.
  - There is always exactly one IDLE cycle between grants.
- HEADER:
  - When slot_free, load m_tdata = grant_id zero-extended, m_tlast = 0, m_tvalid = 1, then go to DATA.
  - While not slot_free, stay in HEADER.
- DATA:
  - s_tready[grant_id] = slot_free; all other bits are 0.
  - On a source handshake:
    - load the beat and increment the beat count;
    - m_tlast = s_tlast, or 1 if the count reaches MAX_BURST (MAX_BURST ≠ 0).
  - Packet end: if s_tlast or the count limit is hit, go to IDLE and set rr pointer = grant_id + 1 (mod N_SOURCES).
  - Forced release without s_tlast: burst_truncated pulses in the following cycle. The remainder of the source packet is treated as a new packet later.
  - If the granted s_tvalid drops mid-packet, the grant is held indefinitely. Requests from other sources are ignored.
- Latency, with m_tready held at 1 and a request in cycle 0:
  - cycle 1: grant_id valid, busy = 1;
  - cycle 2: header beat on m_*;
  - cycle 3: first data beat.
  - Then one beat per cycle.
- Backpressure: with m_tready = 0, no source beat is accepted and m_* are stable until m_tready rises.
- N_SOURCES = 1: the arbiter degenerates, but the header and MAX_BURST behaviour are unchanged.

Decomposition:
- Shared package uart_sched_pkg holds:
  - the state enum (IDLE, HEADER, DATA);
  - a function computing the grant index width;
  - the header pad constant (zero).
- Sub-module rr_picker (combinational): inputs request vector and pointer; outputs found and index. Reusable by future arbiters.

Test Plan:
- Single request: source 2 sends 0x41, 0x42 (tlast on 0x42) with m_tready = 1 → m_* carries 0x02 (cycle 2), 0x41, 0x42 with m_tlast only on 0x42; busy falls; rr pointer = 3.
- Fairness: sources 0, 1 and 3 each continuously send 1-beat packets → output headers in order 0x00, 0x01, 0x03, 0x00, …; no source is granted twice consecutively.
- Backpressure: m_tready toggles 1, 0, 0, 1 during a 4-beat packet → every byte appears exactly once in order; m_tdata is stable while m_tvalid = 1 and m_tready = 0; s_tready is low in stall cycles.
- Truncation: MAX_BURST = 4, source 1 sends a 6-beat packet → first grant emits header plus 4 beats with m_tlast on beat 4 and one burst_truncated pulse; the next grant to source 1 carries beats 5–6.
- Reset mid-packet: reset low during beat 2 of 4 → all outputs are 0 immediately (asynchronous); after release, state is IDLE and the next grant starts from source 0.
- ID_HEADER = 0, N_SOURCES = 1: a 3-beat packet → exactly 3 output beats, no header.
